display_scanner: RTL

- Drives the 8-digit multiplexed seven-segment display.
- Produces the rotating active-low one-hot digit select that feeds the downstream digit-data multiplexer's `sel` input and the display anode pins.
- Provides per-digit enable masking, an inter-digit blanking gap that suppresses ghosting, and a frame-start pulse for upstream data latching.

---
 rtl/display_pkg.sv | 14 +
 rtl/next_digit_finder.sv | 30 +++
 rtl/display_scanner.sv | 104 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: digit count,
// select encoding and the digit index type used by scanner, mux and decoder.
package display_pkg;

   localparam int unsigned DIGITS  = 8;
   localparam logic [7:0]  SEL_OFF = 8'hFF;

   typedef logic [2:0] digit_idx_t;

   function automatic logic [7:0] onehot_low(input digit_idx_t idx);
      return ~(8'b1 << idx);
   endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational circular priority search: first set bit of digit_mask at
// idx+1, idx+2, ... mod 8, with idx itself considered last.
module next_digit_finder
   import display_pkg::*;
(
   input  digit_idx_t  idx,
   input  logic [7:0]  digit_mask,
   output digit_idx_t  next_idx,
   output logic        found,
   output logic        wrapped
);

   digit_idx_t cand;

   always_comb begin
      next_idx = idx;
      found    = 1'b0;
      cand     = idx;
      // k == DIGITS truncates to an offset of 0, so idx is the final candidate
      for (int unsigned k = 1; k <= DIGITS; k++) begin
         cand = idx + digit_idx_t'(k);
         if (!found && digit_mask[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
      wrapped = found && (next_idx <= idx);
   end

endmodule

// File: rtl/display_scanner.sv
// Eight-digit multiplexed display scanner with per-digit masking, blanking gap
// and frame tick. Define SCAN_DIMMING_EN to add the brightness PWM input.
module display_scanner
   import display_pkg::*;
#(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned BLANK = 500
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  digit_mask,
`ifdef SCAN_DIMMING_EN
   input  logic [3:0]  brightness,
`endif
   output logic [7:0]  sel,
   output logic [2:0]  idx,
   output logic        frame_tick
);

   localparam int unsigned CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   digit_idx_t    idx_q, idx_d;
   logic [7:0]    sel_q, sel_d;
   logic          frame_tick_q, frame_tick_d;

   digit_idx_t    next_idx;
   logic          found;
   logic          wrapped;
   logic          last_slot;
   logic          blank_done;
   logic          duty_ok;

   next_digit_finder u_finder (
      .idx        (idx_q),
      .digit_mask (digit_mask),
      .next_idx   (next_idx),
      .found      (found),
      .wrapped    (wrapped)
   );

   assign last_slot = (cnt_q == CW'(DIV - 1));

   generate
      if (BLANK == 0) begin : g_no_blank
         always_comb blank_done = 1'b1;
      end else begin : g_blank
         always_comb blank_done = (cnt_q >= CW'(BLANK));
      end
   endgenerate

`ifdef SCAN_DIMMING_EN
   logic [3:0] phase_q, phase_d;

   // Phase runs even while the scan is frozen so PWM stays periodic
   always_comb begin
      phase_d = phase_q + 4'd1;
      duty_ok = (phase_q <= brightness);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= '0;
      else        phase_q <= phase_d;
   end
`else
   always_comb duty_ok = 1'b1;
`endif

   always_comb begin
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      frame_tick_d = 1'b0;
      sel_d        = SEL_OFF;
      if (en) begin
         cnt_d = last_slot ? '0 : cnt_q + 1'b1;
         if (last_slot && found) begin
            idx_d        = next_idx;
            frame_tick_d = wrapped;
         end
      end
      if (en && digit_mask[idx_q] && blank_done && duty_ok)
         sel_d = onehot_low(idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sel_q        <= SEL_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sel_q        <= sel_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign sel        = sel_q;
   assign idx        = idx_q;
   assign frame_tick = frame_tick_q;

endmodule
